// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with sized loads/stores; word-crossing accesses take two beats.
// Optional DMEM_MISALIGN_TRAP_EN rejects any misaligned access instead of splitting it.
module data_memory_ctrl #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 64,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = OFF_W + 2;
    localparam int CAP   = DEPTH * BYTES;

    logic [DATA_W-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    logic              in_split, accept, err_in, cross_in, do_write;
    logic [LW-1:0]     nb_in, cur_nb;
    logic [OFF_W-1:0]  off_in, off_reg, cur_off;
    logic [IDX_W-1:0]  word_in, word_reg, cur_word;
    logic [ADDR_W:0]   end_addr;
    logic [1:0]        size_reg, cur_size;
    logic              uns_reg, write_reg, cur_uns;
    logic [DATA_W-1:0] wdata_reg, hold_reg, cur_wdata, rword, wword, asm_data, ext_data;
    logic [BYTES-1:0]  lane_en;
    logic [OFF_W-1:0]  lane_kk [BYTES];
    logic              sbit;

    assign nb_in    = LW'(1) << req_size;
    assign off_in   = req_addr[OFF_W-1:0];
    assign word_in  = req_addr[OFF_W +: IDX_W];
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(nb_in);
    assign accept   = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err_in   = (end_addr > (ADDR_W+1)'(CAP)) || (nb_in > LW'(BYTES))
                   || ((req_addr[3:0] & 4'(nb_in - LW'(1))) != 4'd0);
    assign cross_in  = 1'b0;
    assign in_split  = 1'b0;
    assign req_ready = 1'b1;
`else
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state_reg, state_next;

    assign err_in    = (end_addr > (ADDR_W+1)'(CAP)) || (nb_in > LW'(BYTES));
    assign cross_in  = ({2'b00, off_in} + nb_in) > LW'(BYTES);
    assign in_split  = (state_reg == SPLIT);
    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !err_in && cross_in) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    // Beat-local view: the second beat replays the latched request against word w+1.
    assign cur_size  = in_split ? size_reg  : req_size;
    assign cur_uns   = in_split ? uns_reg   : req_unsigned;
    assign cur_off   = in_split ? off_reg   : off_in;
    assign cur_wdata = in_split ? wdata_reg : req_wdata;
    assign cur_word  = in_split ? word_reg + IDX_W'(1) : word_in;
    assign cur_nb    = LW'(1) << cur_size;
    assign rword     = mem[cur_word];
    assign do_write  = !reset && ((accept && !err_in && req_write) || (in_split && write_reg));

    // Each lane maps to request byte k = lane position (offset by BYTES in the high beat) - offset.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            localparam logic [LW-1:0] BASE_LO = LW'(gi);
            localparam logic [LW-1:0] BASE_HI = LW'(gi + BYTES);
            logic [LW-1:0] base, k;
            assign base         = in_split ? BASE_HI : BASE_LO;
            assign k            = base - {2'b00, cur_off};
            assign lane_en[gi]  = (base >= {2'b00, cur_off}) && (k < cur_nb);
            assign lane_kk[gi]  = k[OFF_W-1:0];
            assign wword[8*gi +: 8] = cur_wdata[8*k[OFF_W-1:0] +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_en[i]) mem[cur_word][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_comb begin
        asm_data = in_split ? hold_reg : '0;
        for (int i = 0; i < BYTES; i++) begin
            if (lane_en[i]) asm_data[8*lane_kk[i] +: 8] = rword[8*i +: 8];
        end
    end

    always_comb begin
        case (cur_size)
            2'd0:    sbit = asm_data[7];
            2'd1:    sbit = asm_data[15];
            2'd2:    sbit = asm_data[31];
            default: sbit = asm_data[DATA_W-1];
        endcase
        for (int b = 0; b < DATA_W; b++) begin
            ext_data[b] = (b < 8 * int'(cur_nb)) ? asm_data[b] : (!cur_uns && sbit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            size_reg  <= '0;
            uns_reg   <= 1'b0;
            write_reg <= 1'b0;
            off_reg   <= '0;
            word_reg  <= '0;
            wdata_reg <= '0;
            hold_reg  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (in_split) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= write_reg ? '0 : ext_data;
            end else if (accept) begin
                if (err_in) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end else if (cross_in) begin
                    size_reg  <= req_size;
                    uns_reg   <= req_unsigned;
                    write_reg <= req_write;
                    off_reg   <= off_in;
                    word_reg  <= word_in;
                    wdata_reg <= req_wdata;
                    hold_reg  <= asm_data;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= req_write ? '0 : ext_data;
                end
            end
        end
    end
endmodule
